// File: rtl/fifo_pop_stream.sv
// fifo_pop_stream
//   Drain stage for a synchronous FIFO with registered pop data. It watches
//   the FIFO empty flag, issues pops, captures the pop data one cycle later
//   and re-presents it as a valid/ready stream through a 2-entry buffer.
//   With a continuously ready consumer it sustains one beat per cycle, and it
//   never pops an empty FIFO.
//
//   Optional feature: define FIFO_POP_STREAM_STATS_EN to add the CNT_W
//   parameter and the xfer_cnt_o accepted-beat counter (wraps, reset only).
//
// Ports
//   clk              in   clock, rising edge
//   reset            in   asynchronous active-low reset
//   fifo_empty_i     in   FIFO empty flag
//   fifo_pop_o       out  pop request to the FIFO (combinational)
//   fifo_pop_data_i  in   FIFO pop data, valid the cycle after fifo_pop_o
//   flush_i          in   synchronous discard of buffered and in-flight beats
//   out_valid_o      out  stream valid (registered)
//   out_data_o       out  stream data (registered)
//   out_ready_i      in   stream ready
//   xfer_cnt_o       out  accepted-beat count (stats build only)

module fifo_pop_stream #(
    parameter int unsigned DATA_W = 1
`ifdef FIFO_POP_STREAM_STATS_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty_i,
    output logic              fifo_pop_o,
    input  logic [DATA_W-1:0] fifo_pop_data_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    input  logic              out_ready_i
`ifdef FIFO_POP_STREAM_STATS_EN
    ,
    output logic [CNT_W-1:0]  xfer_cnt_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

    occ_e              cnt_q, cnt_d;
    logic              head_q, head_d;
    logic              inflight_q, inflight_d;
    logic [DATA_W-1:0] buf_q [2];

    logic              deq;
    logic              arrive;
    logic              tail;
    logic [2:0]        level;

    assign out_valid_o = (cnt_q != EMPTY);
    assign out_data_o  = buf_q[head_q];
    assign deq         = out_valid_o & out_ready_i;

    // A beat arriving in a flush cycle is dropped rather than written.
    assign arrive      = inflight_q & ~flush_i;

    // Tail slot is head + occupancy (mod 2). Arrival only happens in EMPTY or
    // ONE, so this never aliases a live entry.
    assign tail        = head_q ^ (cnt_q == ONE);

    // Occupancy after this edge, counting the in-flight beat; deq implies
    // cnt_q >= 1 so the subtraction cannot underflow.
    always_comb begin
        level      = 3'(cnt_q) + 3'(inflight_q) - 3'(deq);
        fifo_pop_o = reset & ~flush_i & ~fifo_empty_i & (level < 3'd2);
    end

    always_comb begin
        cnt_d      = cnt_q;
        head_d     = head_q ^ deq;
        inflight_d = fifo_pop_o;
        if (flush_i) begin
            cnt_d = EMPTY;
        end else begin
            unique case (cnt_q)
                EMPTY: if (arrive) cnt_d = ONE;
                ONE: begin
                    if (arrive && !deq)      cnt_d = TWO;
                    else if (!arrive && deq) cnt_d = EMPTY;
                end
                TWO:     if (deq) cnt_d = ONE;
                default: cnt_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= EMPTY;
            head_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            head_q     <= head_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else if (arrive) begin
            buf_q[tail] <= fifo_pop_data_i;
        end
    end

`ifdef FIFO_POP_STREAM_STATS_EN
    logic [CNT_W-1:0] xfer_q;

    // Counts every accepted beat, including one accepted in a flush cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xfer_q <= '0;
        end else if (deq) begin
            xfer_q <= xfer_q + 1'b1;
        end
    end

    assign xfer_cnt_o = xfer_q;
`else
    // No transfer counter in this build.
`endif

    // The pop rule keeps buffered + in-flight beats at or below two, so a
    // beat can never arrive while the buffer is full and not draining.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!reset)
        !(arrive && (cnt_q == TWO) && !deq)
    );

endmodule
